// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared constants, state encoding and lane helper for the FP byte
//          sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

   localparam int FP_W      = 32;
   localparam int BYTE_W    = 8;
   localparam int NUM_BYTES = 4;
   localparam int CNT_W     = 2;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } seq_state_t;

   // Stream slot -> byte lane of the 32-bit word.
   function automatic logic [CNT_W-1:0] slot_to_lane(
      input logic [CNT_W-1:0] slot,
      input logic             lsb_first
   );
      logic [CNT_W-1:0] c_last;
      c_last = CNT_W'(NUM_BYTES - 1);
      return lsb_first ? slot : (c_last - slot);
   endfunction

endpackage

`default_nettype wire

// File: rtl/byte_slot_mux.sv
// ============================================================================
// Module : byte_slot_mux
// Brief  : Byte-slot select (32->8) and byte write-mask decode (8->32),
//          indexed by the stream slot and the configured byte order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_slot_mux
   import fp_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
)
(
   input  logic [CNT_W-1:0]  i_slot,
   input  logic [FP_W-1:0]   i_word,
   output logic [BYTE_W-1:0] o_byte,
   output logic [FP_W-1:0]   o_wr_mask
);

   logic [CNT_W-1:0]     w_lane;
   logic [NUM_BYTES-1:0] w_lane_we;

   assign w_lane = slot_to_lane(i_slot, LSB_FIRST);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         assign w_lane_we[gi]                      = (w_lane == CNT_W'(gi));
         assign o_wr_mask[gi*BYTE_W +: BYTE_W]     = {BYTE_W{w_lane_we[gi]}};
      end
   endgenerate

   always_comb begin
      o_byte = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (w_lane_we[i]) begin
            o_byte = i_word[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp_byte_sequencer.sv
// ============================================================================
// Module : fp_byte_sequencer
// Brief  : Byte-serial operand loader and result streamer around an external
//          combinational 32-bit FP add/sub unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_byte_sequencer
   import fp_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              clr,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_sub,
   output logic              in_ready,
   output logic [FP_W-1:0]   op_a,
   output logic [FP_W-1:0]   op_b,
   output logic              op_sub,
   input  logic [FP_W-1:0]   fp_result,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic [FP_W-1:0]   r_op_a;
   logic [FP_W-1:0]   r_op_b;
   logic              r_op_sub;
   logic [FP_W-1:0]   r_result;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_last_slot;
   logic [FP_W-1:0]   w_wr_mask;
   logic [FP_W-1:0]   w_in_word;
   logic [BYTE_W-1:0] w_out_byte;

   assign in_ready    = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign out_valid   = (r_state == SEND);
   assign w_in_fire   = ena & in_valid & in_ready;
   assign w_out_fire  = ena & out_valid & out_ready;
   assign w_last_slot = (r_cnt == CNT_W'(NUM_BYTES - 1));
   assign w_in_word   = {NUM_BYTES{in_data}};

   // One slot decoder serves both directions: the counter only ever indexes
   // the operand being loaded or the result being sent, never both at once.
   byte_slot_mux #(
      .LSB_FIRST (LSB_FIRST)
   ) u_slot_mux (
      .i_slot    (r_cnt),
      .i_word    (r_result),
      .o_byte    (w_out_byte),
      .o_wr_mask (w_wr_mask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOAD_A;
         r_cnt   <= '0;
      end else if (ena) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         LOAD_A: begin
            if (w_in_fire) begin
               if (w_last_slot) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = LOAD_B;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
         end
         LOAD_B: begin
            if (w_in_fire) begin
               if (w_last_slot) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = CAPTURE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
         end
         CAPTURE: begin
            w_state_nxt = SEND;
         end
         SEND: begin
            if (w_out_fire) begin
               if (w_last_slot) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = LOAD_A;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = LOAD_A;
         end
      endcase
      // Abort outranks any transfer decided above.
      if (clr) begin
         w_state_nxt = LOAD_A;
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_sub <= 1'b0;
         r_result <= '0;
      end else if (ena && !clr) begin
         if (w_in_fire && (r_state == LOAD_A)) begin
            r_op_a <= (r_op_a & ~w_wr_mask) | (w_in_word & w_wr_mask);
         end
         if (w_in_fire && (r_state == LOAD_B)) begin
            r_op_b <= (r_op_b & ~w_wr_mask) | (w_in_word & w_wr_mask);
            if (w_last_slot) begin
               r_op_sub <= in_sub;
            end
         end
         if (r_state == CAPTURE) begin
            r_result <= fp_result;
         end
      end
   end

   assign op_a     = r_op_a;
   assign op_b     = r_op_b;
   assign op_sub   = r_op_sub;
   assign out_data = out_valid ? w_out_byte : '0;
   assign busy     = !((r_state == LOAD_A) && (r_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_fp_byte_sequencer.sv
// ============================================================================
// Module : tb_fp_byte_sequencer
// Brief  : Self-checking bench; drives one LSB-first and one MSB-first
//          instance with the same stream and checks both against a
//          transaction-level model every cycle.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_byte_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, ena, clr, in_valid, in_sub, out_ready;
   logic [7:0] in_data;

   logic        ir0, ir1, ov0, ov1, bz0, bz1, os0, os1;
   logic [7:0]  od0, od1;
   logic [31:0] oa0, oa1, ob0, ob1, fr0, fr1;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   // model state, index 0 = LSB-first instance, 1 = MSB-first instance
   logic [31:0] m_a[2], m_b[2], m_res[2];
   logic        m_sub[2];
   int          m_nin[2], m_stage[2], m_nout[2];

   always #5 clk = ~clk;

   // ---------------- reference FP unit (via real arithmetic) ----------------
   function automatic real f2r(input logic [31:0] b);
      real r;
      int  e;
      if (b[30:0] == 31'd0) return 0.0;
      r = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin r = r * 2.0; e--; end
      while (e < 0) begin r = r / 2.0; e++; end
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
      return r2f(s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
   endfunction

   assign fr0 = fp_addsub(oa0, ob0, os0);
   assign fr1 = fp_addsub(oa1, ob1, os1);

   fp_byte_sequencer #(.LSB_FIRST(1'b1)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_sub(in_sub), .in_ready(ir0),
      .op_a(oa0), .op_b(ob0), .op_sub(os0), .fp_result(fr0),
      .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .busy(bz0)
   );

   fp_byte_sequencer #(.LSB_FIRST(1'b0)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_sub(in_sub), .in_ready(ir1),
      .op_a(oa1), .op_b(ob1), .op_sub(os1), .fp_result(fr1),
      .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .busy(bz1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: transaction-level byte bookkeeping ----------------
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_sub[i] = 1'b0;
         m_nin[i] = 0; m_stage[i] = 0; m_nout[i] = 0;
      end
   endtask

   task automatic model_step();
      int lane;
      for (int i = 0; i < 2; i++) begin
         if (clr) begin
            m_stage[i] = 0; m_nin[i] = 0; m_nout[i] = 0;
         end else if (m_stage[i] == 0) begin
            if (in_valid) begin
               lane = (i == 0) ? (m_nin[i] % 4) : (3 - (m_nin[i] % 4));
               if (m_nin[i] < 4) m_a[i][lane*8 +: 8] = in_data;
               else              m_b[i][lane*8 +: 8] = in_data;
               m_nin[i]++;
               if (m_nin[i] == 8) begin
                  m_sub[i] = in_sub; m_nin[i] = 0; m_stage[i] = 1;
               end
            end
         end else if (m_stage[i] == 1) begin
            m_res[i]   = fp_addsub(m_a[i], m_b[i], m_sub[i]);
            m_stage[i] = 2;
         end else if (out_ready) begin
            m_nout[i]++;
            if (m_nout[i] == 4) begin
               m_nout[i] = 0; m_stage[i] = 0;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n)   model_reset();
         else if (ena) model_step();
      end
   end

   function automatic logic [7:0] m_byte(input int i);
      int lane;
      lane = (i == 0) ? m_nout[i] : (3 - m_nout[i]);
      return (m_stage[i] == 2) ? m_res[i][lane*8 +: 8] : 8'h00;
   endfunction

   task automatic cmp_inst(input int i, input string p, input logic ir, input logic ov,
                           input logic [7:0] od, input logic bz, input logic [31:0] oa,
                           input logic [31:0] ob, input logic os);
      chk({p, "_in_ready"},  32'(ir), 32'(m_stage[i] == 0));
      chk({p, "_out_valid"}, 32'(ov), 32'(m_stage[i] == 2));
      chk({p, "_out_data"},  32'(od), 32'(m_byte(i)));
      chk({p, "_busy"},      32'(bz), 32'(!(m_stage[i] == 0 && m_nin[i] == 0)));
      chk({p, "_op_a"},      oa, m_a[i]);
      chk({p, "_op_b"},      ob, m_b[i]);
      chk({p, "_op_sub"},    32'(os), 32'(m_sub[i]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cmp_inst(0, "lsb", ir0, ov0, od0, bz0, oa0, ob0, os0);
         cmp_inst(1, "msb", ir1, ov1, od1, bz1, oa1, ob1, os1);
         if (rst_n && ena && !clr && out_ready) begin
            if (ov0) q0.push_back(od0);
            if (ov1) q1.push_back(od1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b, input logic s);
      in_data = b; in_sub = s; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_sub = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] w, input logic s);
      for (int k = 0; k < 4; k++) put(w[k*8 +: 8], (k == 3) ? s : 1'b0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (q0.size() < 4 && n < 30) begin tick(); n++; end
      chk({name, "_drain_count"}, 32'(q0.size()), 32'd4);
      out_ready = 1'b0;
   endtask

   task automatic chk_q(input string name, input logic [7:0] q[$], input logic [31:0] exp);
      chk({name, "_nbytes"}, 32'(q.size()), 32'd4);
      if (q.size() == 4) chk({name, "_bytes"}, {q[0], q[1], q[2], q[3]}, exp);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!ov0 && n < 10) begin tick(); n++; end
      chk({name, "_valid_seen"}, 32'(ov0), 32'd1);
   endtask

   initial begin
      int          lat;
      logic [7:0]  held;

      rst_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
      in_data = 8'h00; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(ir0), 32'd1);
      chk("rst_busy", 32'(bz0), 32'd0);
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_op_a", oa0, 32'h0);
      chk("model_add", fp_addsub(32'h3F800000, 32'h40000000, 1'b0), 32'h40400000);
      chk("model_sub", fp_addsub(32'h40000000, 32'h3F800000, 1'b1), 32'h3F800000);
      rst_n = 1'b1;
      tick();

      // add 1.0 + 2.0
      q0.delete(); q1.delete();
      put_word(32'h3F800000, 1'b0);
      put_word(32'h40000000, 1'b0);
      lat = 1;
      while (!ov0 && lat < 10) begin tick(); lat++; end
      chk("add_latency", 32'(lat), 32'd2);
      chk("add_op_a", oa0, 32'h3F800000);
      chk("add_op_b", ob0, 32'h40000000);
      chk("add_op_sub", 32'(os0), 32'd0);
      drain("add");
      chk_q("add_out", q0, 32'h00004040);

      // subtract 2.0 - 1.0
      q0.delete(); q1.delete();
      put_word(32'h40000000, 1'b0);
      put_word(32'h3F800000, 1'b1);
      chk("sub_op_sub", 32'(os0), 32'd1);
      drain("sub");
      chk_q("sub_out", q0, 32'h0000803F);

      // backpressure
      q0.delete(); q1.delete();
      put_word(32'h3F800000, 1'b0);
      put_word(32'h40000000, 1'b0);
      wait_valid("bp");
      held = od0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_stall_data", 32'(od0), 32'(held));
      end
      for (int k = 0; k < 40 && q0.size() < 4; k++) begin
         out_ready = ~out_ready;
         tick();
      end
      chk("bp_busy_after", 32'(bz0), 32'd0);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      chk_q("bp_out", q0, 32'h00004040);

      // reset mid-load
      put_word(32'h11223344, 1'b0);
      put(8'h55, 1'b0);
      put(8'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst_op_b", ob0, 32'h0);
      chk("mrst_out_valid", 32'(ov0), 32'd0);
      chk("mrst_in_ready", 32'(ir0), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      q0.delete(); q1.delete();
      put_word(32'h40400000, 1'b0);
      put_word(32'h3F800000, 1'b1);
      drain("mrst");
      chk_q("mrst_out", q0, 32'h00000040);

      // clr during SEND with out_ready high
      q0.delete(); q1.delete();
      put_word(32'h3F800000, 1'b0);
      put_word(32'h40000000, 1'b0);
      wait_valid("clr");
      out_ready = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0; out_ready = 1'b0;
      chk("clr_out_valid", 32'(ov0), 32'd0);
      chk("clr_busy", 32'(bz0), 32'd0);
      chk("clr_nbytes", 32'(q0.size()), 32'd0);

      // ena gating mid-load
      put(8'h11, 1'b0);
      ena = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ena_op_a", oa0, 32'h3F800011);
         chk("ena_busy", 32'(bz0), 32'd1);
      end
      ena = 1'b1; in_valid = 1'b0;
      put(8'h22, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b0);
      chk("ena_op_a_full", oa0, 32'h44332211);
      q0.delete(); q1.delete();
      put_word(32'h40000000, 1'b0);
      drain("ena");

      // MSB-first stream on the second instance
      q0.delete(); q1.delete();
      put(8'h3F, 1'b0); put(8'h80, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0);
      chk("msb_op_a", oa1, 32'h3F800000);
      put(8'h40, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0);
      chk("msb_op_b", ob1, 32'h40000000);
      drain("msb");
      chk_q("msb_out", q1, 32'h40400000);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
